set_bit_iterator: RTL and testbench
===================================

# set_bit_iterator

Sequential consumer of the find-first-set operation. It accepts an N-bit vector over a valid/ready handshake and emits every set bit one beat per cycle, LSB first. Each beat carries the bit's one-hot mask, its binary index, its ordinal (0 = first set bit, 1 = second set bit, …) and a last flag. It sits downstream of request/flag collectors, where set bits must be serviced one at a time rather than only the first or second.

## Interface
- WIDTH, 16, vector width; must be ≥ 2.
- IDXW, $clog2(WIDTH), width of the index and ordinal fields (derived, not overridden).

- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- vec_valid_i  input  1  input vector valid.
- vec_i  input  WIDTH  vector to enumerate.
- vec_ready_o  output  1  block can accept a vector.
- bit_valid_o  output  1  output beat valid.
- bit_ready_i  input  1  downstream accepts the beat.
- bit_onehot_o  output  WIDTH  one-hot mask of the current set bit.
- bit_idx_o  output  IDXW  binary index of the current set bit.
- bit_seq_o  output  IDXW  ordinal of the current bit within its vector.
- bit_last_o  output  1  current bit is the highest set bit of the vector.

## Operation
- State machine has two states: IDLE and EMIT. Registers: state, pending[WIDTH-1:0], seq[IDXW-1:0].
- IDLE:
  - vec_ready_o = 1, bit_valid_o = 0.
  - On vec_valid_i & vec_ready_o with vec_i ≠ 0: pending ← vec_i, seq ← 0, go to EMIT.
  - On vec_valid_i & vec_ready_o with vec_i == 0: the vector is consumed and produces no beats; stay in IDLE.
- EMIT:
  - vec_ready_o = 0, bit_valid_o = 1.
  - bit_onehot_o = lowest set bit of pending (bit 0 has highest priority).
  - bit_idx_o = binary encoding of bit_onehot_o.
  - bit_seq_o = seq.
  - bit_last_o = ((pending & ~bit_onehot_o) == 0).
- Handshake in EMIT (bit_valid_o & bit_ready_i):
  - pending ← pending & ~bit_onehot_o, seq ← seq + 1.
  - If bit_last_o, go to IDLE.
- Without a handshake, all bit_* outputs hold stable.
- vec_valid_i is ignored in EMIT. The upstream must hold the vector until vec_ready_o is high.
- All outputs are functions of registered state only; there is no combinational input-to-output path.
- Outputs with bit_valid_o = 0 are don't-care for checking. The implementation drives them from pending = 0, giving onehot 0, idx 0, last 1.

## Timing
- Reset: a clock edge with reset_n = 0 sets state = IDLE, pending = 0, seq = 0.
- Output values after reset: vec_ready_o = 1, bit_valid_o = 0, bit_onehot_o = 0, bit_idx_o = 0, bit_seq_o = 0, bit_last_o = 1.
- Latency: a vector accepted at edge N presents its first beat in the cycle after edge N.
- Throughput: one beat per cycle while bit_ready_i = 1.
- Per-vector cost: k beats for k set bits, plus one IDLE cycle to accept the next vector. A zero vector costs one cycle.
- After the last-beat handshake at edge M, vec_ready_o = 1 in the cycle after M.
- Reset mid-EMIT discards the remaining pending bits. No further beats are produced; the next cycle is IDLE.
- seq never wraps: at most WIDTH beats per vector, so the maximum value is WIDTH-1.

## Structure
- Package set_bit_iterator_pkg holds:
  - typedef enum logic {IDLE, EMIT} iter_state_t;
  - a function onehot_to_idx (OR-reduction encoder), shared with other blocks.
- Sub-module find_first_set #(WIDTH) is combinational: req_i → one-hot gnt_o, bit 0 highest priority. It is instantiated once on pending.
- The top level contains only the FSM, the pending/seq registers and the output assigns.

## Test plan
- WIDTH = 16, vec 16'h0A04, bit_ready_i = 1 → three consecutive beats:
  - onehot 0x0004, idx 2, seq 0;
  - onehot 0x0200, idx 9, seq 1;
  - onehot 0x0800, idx 11, seq 2, last = 1.
  - vec_ready_o = 1 in the following cycle.
- vec 16'h0000 → accepted in one cycle, bit_valid_o stays 0, vec_ready_o stays 1.
- vec 16'hFFFF, bit_ready_i held 1 → 16 beats in 16 consecutive cycles, idx = seq = 0..15, last only on idx 15.
- vec 16'h8001, bit_ready_i low for 3 cycles → idx 0 / onehot 0x0001 held stable for 3 cycles. Then idx 0 is accepted, followed by idx 15, seq 1, last = 1.
- vec 16'h00F0, reset_n low after 2 beats (idx 4, 5) → cycle after the reset edge: bit_valid_o 0, vec_ready_o 1. New vec 16'h0002 then yields a single beat idx 1, seq 0, last 1.
- vec_valid_i high with 16'h0003 during EMIT of a prior vector → not accepted while vec_ready_o = 0. It is accepted in the first IDLE cycle and yields idx 0, then idx 1 with last = 1.

Source files
------------

// File: rtl/set_bit_iterator_pkg.sv
// rtl/set_bit_iterator_pkg.sv - shared types and helpers for the set-bit iterator
package set_bit_iterator_pkg;

  typedef enum logic {IDLE, EMIT} iter_state_t;

  // The encoder works on a fixed maximum width; callers zero-extend and keep the low bits.
  localparam int ENC_W  = 64;
  localparam int ENC_IW = 6;

  // OR-reduction encoder: each set position contributes its index, so a one-hot
  // input yields its binary position and an all-zero input yields 0.
  function automatic logic [ENC_IW-1:0] onehot_to_idx(input logic [ENC_W-1:0] onehot);
    logic [ENC_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < ENC_W; i++) begin
      if (onehot[i]) idx = idx | ENC_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/set_bit_iterator_find_first_set.sv
// rtl/set_bit_iterator_find_first_set.sv - combinational lowest-set-bit selector
module find_first_set #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] gnt_o
);

  // Two's-complement trick isolates the lowest set bit; bit 0 wins.
  assign gnt_o = req_i & (~req_i + WIDTH'(1));

endmodule

// File: rtl/set_bit_iterator.sv
// rtl/set_bit_iterator.sv - enumerates set bits of a vector one beat per cycle, LSB first
module set_bit_iterator
  import set_bit_iterator_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vec_valid_i,
  input  logic [WIDTH-1:0] vec_i,
  output logic             vec_ready_o,
  output logic             bit_valid_o,
  input  logic             bit_ready_i,
  output logic [WIDTH-1:0] bit_onehot_o,
  output logic [IDXW-1:0]  bit_idx_o,
  output logic [IDXW-1:0]  bit_seq_o,
  output logic             bit_last_o
);

  iter_state_t      state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDXW-1:0]  seq_q, seq_d;

  logic [WIDTH-1:0]  gnt;
  logic [ENC_W-1:0]  gnt_ext;
  logic [ENC_IW-1:0] idx_full;
  logic              last;
  logic              unused_idx_bits;

  find_first_set #(.WIDTH(WIDTH)) u_ffs (
    .req_i (pending_q),
    .gnt_o (gnt)
  );

  // Widen the grant to the shared encoder's input width.
  always_comb begin
    gnt_ext = '0;
    gnt_ext[WIDTH-1:0] = gnt;
  end

  assign idx_full        = onehot_to_idx(gnt_ext);
  assign unused_idx_bits = ^idx_full;
  assign last            = ((pending_q & ~gnt) == '0);

  // Outputs come from registered state only; pending is zero whenever IDLE.
  assign vec_ready_o  = (state_q == IDLE);
  assign bit_valid_o  = (state_q == EMIT);
  assign bit_onehot_o = gnt;
  assign bit_idx_o    = idx_full[IDXW-1:0];
  assign bit_seq_o    = seq_q;
  assign bit_last_o   = last;

  // Next-state: load a non-zero vector in IDLE, retire one bit per accepted beat in EMIT.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    seq_d     = seq_q;
    case (state_q)
      IDLE: begin
        if (vec_valid_i && (vec_i != '0)) begin
          pending_d = vec_i;
          seq_d     = '0;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (bit_ready_i) begin
          pending_d = pending_q & ~gnt;
          seq_d     = seq_q + IDXW'(1);
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      seq_q     <= seq_d;
    end
  end

endmodule

// File: tb/tb_set_bit_iterator.sv
// tb/tb_set_bit_iterator.sv - randomized and directed self-checking bench for set_bit_iterator
module tb_set_bit_iterator;

  localparam int WIDTH = 16;
  localparam int IDXW  = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             vec_valid_i;
  logic [WIDTH-1:0] vec_i;
  logic             vec_ready_o;
  logic             bit_valid_o;
  logic             bit_ready_i;
  logic [WIDTH-1:0] bit_onehot_o;
  logic [IDXW-1:0]  bit_idx_o;
  logic [IDXW-1:0]  bit_seq_o;
  logic             bit_last_o;

  set_bit_iterator #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vec_valid_i  (vec_valid_i),
    .vec_i        (vec_i),
    .vec_ready_o  (vec_ready_o),
    .bit_valid_o  (bit_valid_o),
    .bit_ready_i  (bit_ready_i),
    .bit_onehot_o (bit_onehot_o),
    .bit_idx_o    (bit_idx_o),
    .bit_seq_o    (bit_seq_o),
    .bit_last_o   (bit_last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned onehot;
    int unsigned idx;
    int unsigned seq;
    int unsigned last;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    fresh_reset = 1'b0;
  int    beats_seen  = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a vector becomes the list of its set positions in ascending order.
  task automatic push_vector(input logic [WIDTH-1:0] v);
    int k;
    int total;
    beat_t b;
    total = $countones(v);
    k = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        b.onehot = 32'd1 << i;
        b.idx    = i;
        b.seq    = k;
        b.last   = (k == total - 1) ? 1 : 0;
        q.push_back(b);
        k++;
      end
    end
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance the model.
  task automatic cycle(input logic vv, input logic [WIDTH-1:0] v, input logic br, input logic rn);
    @(negedge clk);
    check("vec_ready", vec_ready_o, (q.size() == 0) ? 1 : 0);
    check("bit_valid", bit_valid_o, (q.size() != 0) ? 1 : 0);
    if (q.size() != 0) begin
      check("onehot", bit_onehot_o, q[0].onehot);
      check("idx",    bit_idx_o,    q[0].idx);
      check("seq",    bit_seq_o,    q[0].seq);
      check("last",   bit_last_o,   q[0].last);
    end else if (fresh_reset) begin
      check("rst_onehot", bit_onehot_o, 0);
      check("rst_idx",    bit_idx_o,    0);
      check("rst_seq",    bit_seq_o,    0);
      check("rst_last",   bit_last_o,   1);
    end
    vec_valid_i = vv;
    vec_i       = v;
    bit_ready_i = br;
    reset_n     = rn;
    if (!rn) begin
      q.delete();
      fresh_reset = 1'b1;
    end else if (q.size() == 0) begin
      if (vv && v != '0) begin
        push_vector(v);
        fresh_reset = 1'b0;
      end
    end else if (br) begin
      void'(q.pop_front());
      beats_seen++;
    end
  endtask

  task automatic idle_cycles(input int n, input logic br);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, br, 1'b1);
  endtask

  initial begin
    logic             hold_vv;
    logic [WIDTH-1:0] hold_vec;
    bit               was_idle;
    int               mode;

    reset_n     = 1'b0;
    vec_valid_i = 1'b0;
    vec_i       = '0;
    bit_ready_i = 1'b0;

    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Three-bit vector at full throughput, then idle.
    cycle(1'b1, 16'h0A04, 1'b1, 1'b1);
    idle_cycles(4, 1'b1);

    // Zero vector is swallowed in one cycle.
    cycle(1'b1, 16'h0000, 1'b1, 1'b1);
    idle_cycles(2, 1'b1);

    // All ones: sixteen back-to-back beats.
    cycle(1'b1, 16'hFFFF, 1'b1, 1'b1);
    idle_cycles(17, 1'b1);

    // Backpressure holds the first beat stable.
    cycle(1'b1, 16'h8001, 1'b1, 1'b1);
    idle_cycles(3, 1'b0);
    idle_cycles(3, 1'b1);

    // Reset in the middle of a vector, then a fresh single-bit vector.
    cycle(1'b1, 16'h00F0, 1'b1, 1'b1);
    idle_cycles(2, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0002, 1'b1, 1'b1);
    idle_cycles(2, 1'b1);

    // A vector offered during EMIT waits for the first IDLE cycle.
    cycle(1'b1, 16'h0030, 1'b1, 1'b1);
    cycle(1'b1, 16'h0003, 1'b1, 1'b1);
    cycle(1'b1, 16'h0003, 1'b1, 1'b1);
    cycle(1'b1, 16'h0003, 1'b1, 1'b1);
    idle_cycles(3, 1'b1);

    // Random traffic; an offered vector is held until it is consumed.
    hold_vv  = 1'b0;
    hold_vec = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!hold_vv && ($urandom_range(0, 3) != 0)) begin
        hold_vv = 1'b1;
        mode = $urandom_range(0, 4);
        case (mode)
          0:       hold_vec = '0;
          1:       hold_vec = WIDTH'($urandom & $urandom & $urandom);
          2:       hold_vec = WIDTH'(32'd1 << $urandom_range(0, WIDTH - 1));
          3:       hold_vec = '1;
          default: hold_vec = WIDTH'($urandom);
        endcase
      end
      was_idle = (q.size() == 0);
      if ($urandom_range(0, 99) == 0) begin
        cycle(hold_vv, hold_vec, $urandom_range(0, 3) != 0, 1'b0);
      end else begin
        cycle(hold_vv, hold_vec, $urandom_range(0, 3) != 0, 1'b1);
        if (was_idle && hold_vv) hold_vv = 1'b0;
      end
    end
    idle_cycles(WIDTH + 2, 1'b1);
    check("drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
